// File: rtl/dmem_sized_if.sv
// Request/response bus between a memory-stage master and the sized data memory.
interface dmem_sized_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ready;
    logic        rvalid;
    logic [31:0] rd;
    logic        err;

    modport master (
        output req, we, size, uns, a, wd,
        input  ready, rvalid, rd, err
    );

    modport slave (
        input  req, we, size, uns, a, wd,
        output ready, rvalid, rd, err
    );
endinterface

// File: rtl/dmem_sized.sv
// Sized little-endian data memory with req/ready handshake, WAIT wait states
// and a single-cycle rvalid response. Faulting accesses never touch memory.
module dmem_sized #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input logic         clk,
    input logic         reset_n,
    dmem_sized_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_LD = 3'(WAIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    if (WAIT < 0 || WAIT > 7 || DEPTH < 1) begin : g_param_check
        $error("dmem_sized: WAIT must be 0..7 and DEPTH >= 1");
    end

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [31:0]   a_q;
    logic [31:0]   wd_q;
    logic          we_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [31:0]   rd_q;
    logic          err_q;

    logic [AW-1:0] idx;
    logic          bad;
    logic          access;
    logic [31:0]   wmask;
    logic [31:0]   wdata;
    logic [31:0]   word;
    logic [31:0]   load_val;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
        logic signed [7:0]  sb;
        logic signed [31:0] sw;
        sb = b;
        sw = sb;
        return zext ? {24'd0, b} : sw;
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = h;
        sw = sh;
        return zext ? {16'd0, h} : sw;
    endfunction

    assign bus.ready  = (state == IDLE);
    assign bus.rvalid = (state == DONE);
    assign bus.rd     = rd_q;
    assign bus.err    = err_q;

    assign access = (state == BUSY) && (cnt == 3'd0);

    // Decode the captured request: fault detection, store lane mask/data, load lane extraction.
    always_comb begin
        idx      = a_q[AW+1:2];
        bad      = 1'b0;
        wmask    = '0;
        wdata    = '0;
        load_val = '0;
        case (size_q)
            SZ_B: begin
                wmask = 32'h0000_00FF << {a_q[1:0], 3'b000};
                wdata = {4{wd_q[7:0]}};
            end
            SZ_H: begin
                bad   = a_q[0];
                wmask = a_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata = {2{wd_q[15:0]}};
            end
            SZ_W: begin
                bad   = (a_q[1:0] != 2'b00);
                wmask = '1;
                wdata = wd_q;
            end
            default: bad = 1'b1;
        endcase
        if ({2'b00, a_q[31:2]} >= 32'(DEPTH)) bad = 1'b1;
        word = mem[idx];
        case (size_q)
            SZ_B:    load_val = ext_byte(word[{a_q[1:0], 3'b000} +: 8], uns_q);
            SZ_H:    load_val = ext_half(word[{a_q[1], 4'b0000} +: 16], uns_q);
            default: load_val = word;
        endcase
    end

    // Control FSM plus the registered response; reset aborts any access not yet performed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state <= BUSY;
                        cnt   <= WAIT_LD;
                    end
                end
                BUSY: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= DONE;
                        err_q <= bad;
                        rd_q  <= (bad || we_q) ? 32'd0 : load_val;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are captured at accept so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req) begin
            a_q    <= bus.a;
            wd_q   <= bus.wd;
            we_q   <= bus.we;
            size_q <= bus.size;
            uns_q  <= bus.uns;
        end
    end

    // Lane-masked store at the access edge; suppressed for faulting accesses and during reset.
    always_ff @(posedge clk) begin
        if (reset_n && access && we_q && !bad) begin
            assert (!$isunknown(wdata & wmask))
                else $warning("dmem_sized: store data has X/Z bits in written lanes");
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
        end
    end
endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: three instances (WAIT=1, 3, 0) on a shared
// clock and reset; stimulus pushes expected responses, a monitor pops them.
module tb_dmem_sized;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [1:0]  size_v [3];
    logic [2:0]  uns_v;
    logic [31:0] a_v  [3];
    logic [31:0] wd_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  rvalid_v;
    logic [2:0]  err_v;
    logic [31:0] rd_v [3];

    int          vectors     = 0;
    int          miscompares = 0;
    int          pulses [3]  = '{0, 0, 0};
    logic [34:0] exp_q [$];
    logic [34:0] mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        dmem_sized_if dif ();
        assign dif.req     = req_v[g];
        assign dif.we      = we_v[g];
        assign dif.size    = size_v[g];
        assign dif.uns     = uns_v[g];
        assign dif.a       = a_v[g];
        assign dif.wd      = wd_v[g];
        assign ready_v[g]  = dif.ready;
        assign rvalid_v[g] = dif.rvalid;
        assign err_v[g]    = dif.err;
        assign rd_v[g]     = dif.rd;
        dmem_sized #(.DEPTH(DEPTH), .WAIT(W)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (dif)
        );
    end

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rvalid_v[i]) begin
                pulses[i]++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rvalid: inst %0d gave rd=0x%08h err=%b, required no response",
                             i, rd_v[i], err_v[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_inst", 32'(i), 32'(mon_e[34:33]));
                    check("resp_rd", rd_v[i], mon_e[31:0]);
                    check("resp_err", 32'(err_v[i]), 32'(mon_e[32]));
                end
            end
        end
    end

    // One handshake; inputs are scrambled right after accept to prove they were captured.
    task automatic access(input int i, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int lows;
        bit seen;
        @(negedge clk);
        req_v[i]  = 1'b1;
        we_v[i]   = w;
        size_v[i] = sz;
        uns_v[i]  = u;
        a_v[i]    = addr;
        wd_v[i]   = data;
        exp_q.push_back({i[1:0], exp_err, exp_rd});
        @(posedge clk);
        #1;
        req_v[i] = 1'b0;
        we_v[i]  = ~w;
        a_v[i]   = 32'hFFFF_FFFF;
        wd_v[i]  = ~data;
        uns_v[i] = ~u;
        lat  = -1;
        lows = 0;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (!ready_v[i]) lows++;
            if (rvalid_v[i]) begin
                seen = 1'b1;
                lat  = n - 1;
            end
        end
        check("rvalid_latency", 32'(lat), 32'(wait_of(i) + 1));
        check("ready_low_cycles", 32'(lows), 32'(wait_of(i) + 2));
        @(negedge clk);
        check("ready_after_done", 32'(ready_v[i]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dat [4];
        int          gap;
        bit          got;
        int          p1;

        dat = '{32'h0BAD_F00D, 32'h600D_CAFE, 32'h1357_9BDF, 32'h2468_ACE0};
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; size_v[i] = 2'b10; uns_v[i] = 1'b0;
            a_v[i] = '0; wd_v[i] = '0;
        end

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(ready_v[i]), 32'd1);
            check("reset_rvalid", 32'(rvalid_v[i]), 32'd0);
            check("reset_rd", rd_v[i], 32'd0);
            check("reset_err", 32'(err_v[i]), 32'd0);
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) check("idle_no_rvalid", 32'(pulses[i]), 32'd0);

        // Word store then load, WAIT=1
        access(0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte and halfword lanes
        access(0, 1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00A5, 32'h0, 1'b0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEA5_BEEF, 1'b0);
        access(0, 1'b0, 2'b00, 1'b0, 32'hA, 32'h0, 32'hFFFF_FFA5, 1'b0);
        access(0, 1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 32'h0000_00A5, 1'b0);
        access(0, 1'b1, 2'b01, 1'b0, 32'h8, 32'h0000_1234, 32'h0, 1'b0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEA5_1234, 1'b0);
        access(0, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'hFFFF_DEA5, 1'b0);
        access(0, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h0000_DEA5, 1'b0);
        access(0, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h0000_0034, 1'b0);

        // Error cases leave memory untouched
        access(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 32'h0, 1'b0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
        access(0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_FFFF, 32'h0, 1'b1);
        access(0, 1'b1, 2'b11, 1'b0, 32'h8, 32'h0000_0000, 32'h0, 1'b1);
        access(0, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        access(0, 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 1'b0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEA5_1234, 1'b0);

        // Request during BUSY is ignored (WAIT=3)
        access(1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
        p1 = pulses[1];
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b10; a_v[1] = 32'h10; wd_v[1] = 32'hCAFE_F00D;
        exp_q.push_back({2'd1, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        @(negedge clk);
        req_v[1] = 1'b1; a_v[1] = 32'h14; wd_v[1] = 32'h1111_1111;
        @(negedge clk);
        req_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_req_one_rvalid", 32'(pulses[1] - p1), 32'd1);
        access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);
        access(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);

        // Reset aborts a pending store
        access(1, 1'b1, 2'b10, 1'b0, 32'h18, 32'h55AA_55AA, 32'h0, 1'b0);
        p1 = pulses[1];
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b10; a_v[1] = 32'h18; wd_v[1] = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready_v[1]), 32'd1);
        check("abort_rd_cleared", rd_v[1], 32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_rvalid", 32'(pulses[1] - p1), 32'd0);
        access(1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'h55AA_55AA, 1'b0);

        // WAIT=0 back-to-back with req held high
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd2, 1'b0, 32'h0});
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; size_v[2] = 2'b10; a_v[2] = 32'h20; wd_v[2] = dat[0];
        for (int j = 0; j < 4; j++) begin
            gap = -1;
            got = 1'b0;
            for (int n = 1; n <= 20 && !got; n++) begin
                @(negedge clk);
                if (rvalid_v[2]) begin
                    got = 1'b1;
                    gap = n;
                end
            end
            check("b2b_rvalid_spacing", 32'(gap), (j == 0) ? 32'd2 : 32'd3);
            if (j < 3) begin
                a_v[2]  = 32'h20 + 32'(4 * (j + 1));
                wd_v[2] = dat[j + 1];
            end else begin
                req_v[2] = 1'b0;
            end
        end
        @(negedge clk);
        for (int j = 0; j < 4; j++)
            access(2, 1'b0, 2'b10, 1'b0, 32'h20 + 32'(4 * j), 32'h0, dat[j], 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
Parametrised data memory for the pipelined MIPS core. It supports byte, halfword and word stores, and sign- or zero-extended loads on little-endian byte lanes. Every access goes through a req/ready handshake with a configurable number of wait states, and the response is a single-cycle rvalid pulse. Misaligned, out-of-range and reserved-size accesses are flagged and never modify memory, so a stall-capable memory stage can replace the fixed single-cycle data memory.

Parameters:
DEPTH, 64, number of 32-bit words; legal word index is 0..DEPTH-1.
WAIT, 1, wait-state cycles between accept and access; legal range 0..7.

Ports:
clk  input  1  clock; all state updates on posedge.
reset_n  input  1  synchronous active-low reset.
req  input  1  access request; sampled only when ready=1.
we  input  1  1 = store, 0 = load.
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
uns  input  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for word loads and stores.
a  input  32  byte address.
wd  input  32  store data; byte/half taken from wd[7:0] / wd[15:0].
ready  output  1  high only in IDLE.
rvalid  output  1  one-cycle response pulse.
rd  output  32  load result, valid while rvalid=1.
err  output  1  access error, valid while rvalid=1.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - state=IDLE, wait counter=0, rvalid=0, rd=0, err=0.
  - Memory array is not cleared.
  - Reset wins over every simultaneous event.
  - An in-flight access whose access edge has not occurred is aborted; a pending store is never written.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready=1. On req=1, capture a, we, size, uns, wd; load counter with WAIT; go to BUSY.
  - BUSY: if counter!=0, decrement it. If counter==0, perform the access (store write or rd/err register update) at this edge and go to DONE.
  - DONE: rvalid=1 for exactly one cycle, then go to IDLE unconditionally.
- Timing and throughput:
  - rvalid rises WAIT+1 edges after the accepting edge.
  - One access completes per WAIT+3 cycles.
  - req while ready=0 is ignored; it is not queued.
  - Captured fields are stable; input changes after accept have no effect.
- Error conditions; err=1 in DONE, with no write and rd=0:
  - halfword with a[0]=1;
  - word with a[1:0]!=0;
  - size=11;
  - a[31:2] >= DEPTH.
- Store lanes (little-endian):
  - Byte writes lane a[1:0], i.e. bits [8*a[1:0]+7 : 8*a[1:0]].
  - Halfword writes bits [16*a[1]+15 : 16*a[1]].
  - Word writes all 32 bits.
  - Unselected lanes are preserved.
  - A successful store returns rd=0, err=0.
- Load lanes:
  - Select the same lane as the store rules.
  - Extend to 32 bits using uns; word loads return the whole word.
  - Load data is registered at the access edge; rd holds its value until the next access edge or reset.
- Assertion: at the access edge of a store, wd must have no X/Z bits in the written lanes; otherwise issue a $warning.
- Elaboration: $error if WAIT > 7 or DEPTH < 1.

Test Plan:
1. Reset then idle: hold reset_n=0 for 2 cycles, release -> ready=1, rvalid=0, rd=0, err=0; req held 0 -> no rvalid ever.
2. Word store then load, WAIT=1: store a=0x8, wd=0xDEADBEEF -> rvalid 2 edges after accept, err=0, rd=0; ready low for 3 cycles. Load word a=0x8 -> rd=0xDEADBEEF.
3. Byte/half lanes: over word 0xDEADBEEF at 0x8:
   - store byte wd=0x000000A5 at a=0xA -> word becomes 0xDEA5BEEF;
   - load byte a=0xA, uns=0 -> 0xFFFFFFA5; uns=1 -> 0x000000A5;
   - store half wd=0x1234 at a=0x8 -> word 0xDEA51234;
   - load half a=0xA, uns=0 -> 0xFFFFDEA5.
4. Errors: word load a=0x6, half store a=0x3, size=11, word access a=4*DEPTH -> err=1, rd=0 for each; memory contents unchanged on read-back.
5. Handshake and reset abort (WAIT=3):
   - Pulse req again during BUSY -> ignored; exactly one rvalid per accept.
   - Accept a store, assert reset_n=0 two cycles later -> no rvalid, target word unchanged, ready=1 after release.
6. WAIT=0 back-to-back: req held 1 continuously with 4 word stores -> 4 rvalid pulses spaced 3 cycles apart; all 4 words read back correct.
